// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller.
//  - Stage indices into the hold vector (stall_stat).
//  - Stall bus type and the stall request bundle.
//  - Redirect FSM state encoding.
package pipe_ctrl_pkg;

  localparam int STALL_W     = 6;
  localparam int STG_PC      = 0;
  localparam int STG_IFID    = 1;
  localparam int STG_IDEX_IN = 2;
  localparam int STG_IDEX    = 3;
  localparam int STG_EXMEM   = 4;
  localparam int STG_WB      = 5;

  // Number of stages that may raise a stall request (IF, ID, EX, MEM)
  localparam int NUM_REQ     = 4;

  typedef logic [STALL_W-1:0] stall_bus_t;

  typedef struct packed {
    logic mem_r;  // level 4
    logic ex_r;   // level 3
    logic id_r;   // level 2
    logic if_r;   // level 1
  } stall_req_t;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pipe_ctrl_stall_merge.sv
// Priority-to-thermometer encoder for per-stage stall requests.
//  req   : stall request bundle (if=1, id=2, ex=3, mem=4)
//  stall : hold vector; the highest requesting level k sets bits 0..k,
//          everything above stays clear. No request -> all zero.
module stall_merge
  import pipe_ctrl_pkg::*;
(
  input  stall_req_t req,
  output stall_bus_t stall
);

  logic [NUM_REQ-1:0] lvl;

  // lvl[j] is request level j+1
  assign lvl = req;

  // A stage register is held when its own level or any older stage requests.
  // Level 1 (IF) also freezes the PC, so bit 0 is simply "any request".
  always_comb begin
    stall = '0;
    stall[STG_PC] = |lvl;
    for (int i = 1; i <= NUM_REQ; i++) begin
      stall[i] = |(lvl >> (i - 1));
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller.
//  Merges per-stage stall requests into the hold vector stall_stat, detects
//  EX mispredicts (flush + PC redirect), defers the redirect while IF has a
//  fetch in flight, and keeps free-running performance counters.
// Ports
//  clk, rst            clock, synchronous active-high reset
//  rdy                 global ready; low freezes every register here
//  *_stall_req         per-stage stall requests (IF, ID, EX, MEM)
//  if_busy             IF has a fetch in flight, cannot take a new PC
//  ex_is_branch        EX resolved a control transfer
//  ex_branch_pc        resolved target
//  id_pc               PC in ID (the predicted successor)
//  stall_stat          hold vector, bit i holds stage i
//  flush               kill younger instructions
//  redirect_valid/pc   one-cycle PC load request and its target
//  if_discard          IF must drop its in-flight fetch result
//  perf_*              cycle / PC-stall / mispredict counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             if_stall_req,
  input  logic             id_stall_req,
  input  logic             ex_stall_req,
  input  logic             mem_stall_req,
  input  logic             if_busy,
  input  logic             ex_is_branch,
  input  logic [31:0]      ex_branch_pc,
  input  logic [31:0]      id_pc,
  output logic [5:0]       stall_stat,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             if_discard,
  output logic [CNT_W-1:0] perf_cycles,
  output logic [CNT_W-1:0] perf_stalls,
  output logic [CNT_W-1:0] perf_flushes
);

  stall_req_t req;
  stall_bus_t merged;

  assign req = '{mem_r: mem_stall_req, ex_r: ex_stall_req,
                 id_r: id_stall_req,   if_r: if_stall_req};

  stall_merge u_merge (
    .req   (req),
    .stall (merged)
  );

  pc_state_e   state_q, state_d;
  logic [31:0] tgt_q, tgt_d;
  logic        disc_q, disc_d;
  logic        pc_hold;
  logic        mispredict;

  // A branch still held in EX is not acted on until it is released.
  assign mispredict = !rst && ex_is_branch && (ex_branch_pc != id_pc) &&
                      !merged[STG_IDEX];
  assign flush      = mispredict;

  always_comb begin
    state_d        = state_q;
    tgt_d          = tgt_q;
    disc_d         = disc_q;
    pc_hold        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (mispredict) begin
            if (!if_busy) begin
              redirect_valid = 1'b1;
              redirect_pc    = ex_branch_pc;
            end else begin
              tgt_d   = ex_branch_pc;
              disc_d  = 1'b1;
              state_d = PEND;
            end
          end
        end
        PEND: begin
          if (if_busy) begin
            pc_hold = 1'b1;
            // The younger branch always carries the correct path.
            if (mispredict) tgt_d = ex_branch_pc;
          end else if (rdy) begin
            // Gated by rdy so the pulse coincides with the state change
            // and is not repeated while the block is frozen.
            redirect_valid = 1'b1;
            redirect_pc    = mispredict ? ex_branch_pc : tgt_q;
            disc_d         = 1'b0;
            state_d        = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign stall_stat = rst ? '0 : (merged | stall_bus_t'(pc_hold));
  assign if_discard = disc_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tgt_q        <= '0;
      disc_q       <= 1'b0;
      perf_cycles  <= '0;
      perf_stalls  <= '0;
      perf_flushes <= '0;
    end else if (rdy) begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      disc_q       <= disc_d;
      perf_cycles  <= perf_cycles + CNT_W'(1);
      perf_stalls  <= perf_stalls + CNT_W'(stall_stat[STG_PC]);
      perf_flushes <= perf_flushes + CNT_W'(mispredict);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        if_stall_req, id_stall_req, ex_stall_req, mem_stall_req;
  logic        if_busy, ex_is_branch;
  logic [31:0] ex_branch_pc, id_pc;
  logic [5:0]  stall_stat;
  logic        flush, redirect_valid, if_discard;
  logic [31:0] redirect_pc;
  logic [31:0] perf_cycles, perf_stalls, perf_flushes;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_stall_req(if_stall_req), .id_stall_req(id_stall_req),
    .ex_stall_req(ex_stall_req), .mem_stall_req(mem_stall_req),
    .if_busy(if_busy), .ex_is_branch(ex_is_branch),
    .ex_branch_pc(ex_branch_pc), .id_pc(id_pc),
    .stall_stat(stall_stat), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_discard(if_discard), .perf_cycles(perf_cycles),
    .perf_stalls(perf_stalls), .perf_flushes(perf_flushes)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  logic [31:0] c_cyc = 0, c_stl = 0, c_fl = 0;
  logic        e_stall0 = 1'b0, e_misp = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Redirect monitor: a redirect is expected exactly when the scoreboard
  // holds a target pushed for this cycle.
  task automatic mon();
    logic exp_v;
    exp_v = (sb.size() != 0);
    chk("redirect_valid", redirect_valid, exp_v);
    if (redirect_valid && exp_v) chk("redirect_pc", redirect_pc, sb.pop_front());
    else if (!redirect_valid)    chk("redirect_pc_idle", redirect_pc, 0);
  endtask

  task automatic adv();
    @(posedge clk);
    if (rst) begin
      c_cyc = 0; c_stl = 0; c_fl = 0;
    end else if (rdy) begin
      c_cyc++;
      if (e_stall0) c_stl++;
      if (e_misp)   c_fl++;
    end
    #1;
    e_stall0 = 1'b0;
    e_misp   = 1'b0;
  endtask

  task automatic cyc(input logic [5:0] es, input logic ef, input logic ed, input bit cd);
    @(negedge clk);
    mon();
    chk("stall_stat", stall_stat, es);
    chk("flush", flush, ef);
    if (cd) chk("if_discard", if_discard, ed);
    chk("perf_cycles", perf_cycles, c_cyc);
    chk("perf_stalls", perf_stalls, c_stl);
    chk("perf_flushes", perf_flushes, c_fl);
    e_stall0 = es[0];
    e_misp   = ef;
    adv();
  endtask

  task automatic br(input logic v, input logic [31:0] tgt, input logic [31:0] ipc);
    ex_is_branch = v;
    ex_branch_pc = tgt;
    id_pc        = ipc;
  endtask

  task automatic reqs(input logic i, input logic d, input logic e, input logic m);
    if_stall_req = i; id_stall_req = d; ex_stall_req = e; mem_stall_req = m;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; if_busy = 1'b0;
    reqs(0, 0, 0, 0);
    br(0, 32'h0, 32'h0);
    adv();
    adv();

    // Outputs forced quiet during reset despite active requests/mispredict
    reqs(0, 0, 0, 1);
    br(1, 32'h200, 32'h104);
    cyc(6'b000000, 0, 0, 1);
    reqs(0, 0, 0, 0);
    br(0, 32'h0, 32'h0);
    rst = 1'b0;
    cyc(6'b000000, 0, 0, 1);

    // Stall merge patterns
    reqs(0, 1, 0, 1); cyc(6'b011111, 0, 0, 1);
    reqs(0, 0, 0, 0); cyc(6'b000000, 0, 0, 1);
    reqs(0, 1, 0, 0); cyc(6'b000111, 0, 0, 1);
    reqs(1, 0, 0, 0); cyc(6'b000011, 0, 0, 1);
    reqs(1, 0, 1, 0); cyc(6'b001111, 0, 0, 1);
    reqs(0, 0, 0, 0);

    // Correctly predicted branch
    br(1, 32'h100, 32'h100); cyc(6'b000000, 0, 0, 1);

    // Mispredict with IF idle: same-cycle redirect
    br(1, 32'h200, 32'h104); sb.push_back(32'h200);
    cyc(6'b000000, 1, 0, 1);
    br(0, 32'h0, 32'h0); cyc(6'b000000, 0, 0, 1);

    // Mispredict while IF busy for 3 more cycles
    if_busy = 1'b1;
    br(1, 32'h200, 32'h104); cyc(6'b000000, 1, 0, 1);
    br(0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) cyc(6'b000001, 0, 1, 1);
    if_busy = 1'b0; sb.push_back(32'h200);
    cyc(6'b000000, 0, 0, 0);
    cyc(6'b000000, 0, 0, 1);

    // Newer mispredict while pending replaces the target
    if_busy = 1'b1;
    br(1, 32'h200, 32'h104); cyc(6'b000000, 1, 0, 1);
    br(1, 32'h300, 32'h104); cyc(6'b000001, 1, 1, 1);
    br(0, 32'h0, 32'h0);     cyc(6'b000001, 0, 1, 1);
    if_busy = 1'b0; sb.push_back(32'h300);
    cyc(6'b000000, 0, 0, 0);
    cyc(6'b000000, 0, 0, 1);

    // rdy low: counters hold, combinational stall still follows inputs
    rdy = 1'b0;
    reqs(0, 0, 0, 1);
    cyc(6'b011111, 0, 0, 1);
    cyc(6'b011111, 0, 0, 1);
    rdy = 1'b1;
    cyc(6'b011111, 0, 0, 1);
    reqs(0, 0, 0, 0);

    // EX held: branch not acted on
    reqs(0, 0, 1, 0);
    br(1, 32'h200, 32'h104); cyc(6'b001111, 0, 0, 1);
    reqs(0, 0, 0, 0);

    // Reset while pending drops the redirect and clears counters
    if_busy = 1'b1;
    cyc(6'b000000, 1, 0, 1);
    br(0, 32'h0, 32'h0);
    rst = 1'b1;
    cyc(6'b000000, 0, 0, 0);
    rst = 1'b0; if_busy = 1'b0;
    for (int i = 0; i < 3; i++) cyc(6'b000000, 0, 0, 1);

    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Overall time bound
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
